l2_request_arbiter: RTL and testbench

L2_REQUEST_ARBITER -- requirements
Module: l2_request_arbiter

---
 rtl/l2_request_arbiter_pkg.sv | 40 ++++
 rtl/l2_request_arbiter_rr_arbiter.sv | 50 +++++
 rtl/l2_request_arbiter.sv | 128 ++++++++++++
 tb/tb_l2_request_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_request_arbiter_pkg.sv
// rtl/l2_request_arbiter_pkg.sv - shared types for the L2 request arbiter
// Contents: cache line geometry, L1 miss entry index, source-id encoding,
// L2 request type enum and the registered L2 request packet.
package l2_request_arbiter_pkg;

   localparam int CACHE_LINE_BYTES = 16;
   localparam int ADDR_BITS        = 32;
   localparam int LINE_OFFSET_BITS = $clog2(CACHE_LINE_BYTES);
   localparam int MISS_ENTRIES     = 16;
   localparam int NUM_SOURCES      = 3;

   typedef logic [ADDR_BITS-LINE_OFFSET_BITS-1:0] cache_line_index_t;
   typedef logic [$clog2(MISS_ENTRIES)-1:0]       l1_miss_entry_idx_t;
   typedef logic [CACHE_LINE_BYTES*8-1:0]         cache_line_data_t;
   typedef logic [CACHE_LINE_BYTES-1:0]           cache_line_byte_mask_t;

   // Source ids double as bit positions in the request/grant vectors.
   typedef enum logic [1:0] {
      SRC_ICACHE = 2'd0,
      SRC_DCACHE = 2'd1,
      SRC_SQ     = 2'd2
   } l2req_source_t;

   typedef enum logic [1:0] {
      LOAD       = 2'd0,
      LOAD_SYNC  = 2'd1,
      STORE      = 2'd2,
      STORE_SYNC = 2'd3
   } l2req_type_t;

   typedef struct packed {
      l2req_source_t         source;
      l1_miss_entry_idx_t    idx;
      cache_line_index_t     adr;
      l2req_type_t           req_type;
      cache_line_data_t      data;
      cache_line_byte_mask_t mask;
   } l2req_packet_t;

endpackage

// File: rtl/l2_request_arbiter_rr_arbiter.sv
// rtl/l2_request_arbiter_rr_arbiter.sv - round-robin arbiter used for L2 source selection
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   request         : one bit per requester
//   update_lru      : advance the priority pointer past the current winner
//   grant           : one-hot winner (combinational)
//   grant_valid     : some requester won this cycle
module rr_arbiter #(
   parameter int NUM_REQUESTERS = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQUESTERS-1:0] request,
   input  logic                      update_lru,
   output logic [NUM_REQUESTERS-1:0] grant,
   output logic                      grant_valid
);

   localparam int PW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
   localparam logic [PW-1:0] LAST = PW'(NUM_REQUESTERS - 1);

   logic [PW-1:0] pointer;
   logic [PW-1:0] cand;
   logic [PW-1:0] winner;

   // Walk the requesters starting at the pointer; first ready one wins.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      winner      = pointer;
      cand        = pointer;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         if (!grant_valid && request[cand]) begin
            grant_valid = 1'b1;
            winner      = cand;
         end
         cand = (cand == LAST) ? '0 : cand + PW'(1);
      end
      grant[winner] = grant_valid;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pointer <= '0;
      end else if (update_lru && grant_valid) begin
         pointer <= (winner == LAST) ? '0 : winner + PW'(1);
      end
   end

endmodule

// File: rtl/l2_request_arbiter.sv
// rtl/l2_request_arbiter.sv - credit-gated round-robin arbiter from L1 miss sources to the L2
// Ports:
//   clk, reset                         : clock, synchronous active-low reset
//   icache_dequeue_*                   : instruction miss queue head (ready/adr/idx) and pop (ack)
//   dcache_dequeue_*                   : data load miss queue head (ready/adr/idx/sync) and pop (ack)
//   sq_dequeue_*                       : store queue head (ready/adr/idx/data/mask/sync) and pop (ack)
//   l2_credit_return                   : L2 freed one request-queue slot
//   drain / drained                    : block new grants / all slots home and nothing in flight
//   l2_request_valid / l2_request      : registered request to the L2, one cycle after the grant
module l2_request_arbiter
   import l2_request_arbiter_pkg::*;
#(
   parameter int NUM_CREDITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  icache_dequeue_ready,
   input  cache_line_index_t     icache_dequeue_adr,
   input  l1_miss_entry_idx_t    icache_dequeue_idx,
   output logic                  icache_dequeue_ack,
   input  logic                  dcache_dequeue_ready,
   input  cache_line_index_t     dcache_dequeue_adr,
   input  l1_miss_entry_idx_t    dcache_dequeue_idx,
   input  logic                  dcache_dequeue_sync,
   output logic                  dcache_dequeue_ack,
   input  logic                  sq_dequeue_ready,
   input  cache_line_index_t     sq_dequeue_adr,
   input  l1_miss_entry_idx_t    sq_dequeue_idx,
   input  cache_line_data_t      sq_dequeue_data,
   input  cache_line_byte_mask_t sq_dequeue_mask,
   input  logic                  sq_dequeue_sync,
   output logic                  sq_dequeue_ack,
   input  logic                  l2_credit_return,
   input  logic                  drain,
   output logic                  drained,
   output logic                  l2_request_valid,
   output l2req_packet_t         l2_request
);

   localparam int CW = $clog2(NUM_CREDITS + 1);
   localparam logic [CW-1:0] FULL = CW'(NUM_CREDITS);

   logic [CW-1:0]          credit_count;
   logic                   grant_enable;
   logic [NUM_SOURCES-1:0] request;
   logic [NUM_SOURCES-1:0] grant;
   logic                   grant_valid;
   l2req_packet_t          next_packet;

   // Requests are masked before the arbiter so that a blocked cycle
   // never moves the round-robin pointer.
   assign grant_enable = reset && (credit_count != '0) && !drain;
   assign request = {sq_dequeue_ready, dcache_dequeue_ready, icache_dequeue_ready}
                    & {NUM_SOURCES{grant_enable}};

   rr_arbiter #(
      .NUM_REQUESTERS(NUM_SOURCES)
   ) u_rr_arbiter (
      .clk        (clk),
      .reset      (reset),
      .request    (request),
      .update_lru (grant_valid),
      .grant      (grant),
      .grant_valid(grant_valid)
   );

   assign icache_dequeue_ack = grant[SRC_ICACHE];
   assign dcache_dequeue_ack = grant[SRC_DCACHE];
   assign sq_dequeue_ack     = grant[SRC_SQ];

   // Loads carry zero data and mask.
   always_comb begin
      next_packet = '0;
      if (grant[SRC_ICACHE]) begin
         next_packet.source   = SRC_ICACHE;
         next_packet.idx      = icache_dequeue_idx;
         next_packet.adr      = icache_dequeue_adr;
         next_packet.req_type = LOAD;
      end else if (grant[SRC_DCACHE]) begin
         next_packet.source   = SRC_DCACHE;
         next_packet.idx      = dcache_dequeue_idx;
         next_packet.adr      = dcache_dequeue_adr;
         next_packet.req_type = dcache_dequeue_sync ? LOAD_SYNC : LOAD;
      end else if (grant[SRC_SQ]) begin
         next_packet.source   = SRC_SQ;
         next_packet.idx      = sq_dequeue_idx;
         next_packet.adr      = sq_dequeue_adr;
         next_packet.req_type = sq_dequeue_sync ? STORE_SYNC : STORE;
         next_packet.data     = sq_dequeue_data;
         next_packet.mask     = sq_dequeue_mask;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         l2_request_valid <= 1'b0;
         l2_request       <= '0;
      end else begin
         l2_request_valid <= grant_valid;
         if (grant_valid) begin
            l2_request <= next_packet;
         end
      end
   end

   // A grant and a return in the same cycle cancel out.
   always_ff @(posedge clk) begin
      if (!reset) begin
         credit_count <= FULL;
      end else begin
         case ({grant_valid, l2_credit_return})
            2'b10:   credit_count <= credit_count - CW'(1);
            2'b01:   if (credit_count != FULL) credit_count <= credit_count + CW'(1);
            default: ;
         endcase
      end
   end

   // The L2 cannot hand back a slot it does not hold.
   always_ff @(posedge clk) begin
      if (reset && l2_credit_return) begin
         assert (credit_count != FULL);
      end
   end

   assign drained = (credit_count == FULL) && !l2_request_valid;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// tb/tb_l2_request_arbiter.sv - self-checking bench for l2_request_arbiter
module tb_l2_request_arbiter;
   import l2_request_arbiter_pkg::*;

   localparam int NC = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  ic_ready, ic_ack;
   cache_line_index_t     ic_adr;
   l1_miss_entry_idx_t    ic_idx;
   logic                  dc_ready, dc_sync, dc_ack;
   cache_line_index_t     dc_adr;
   l1_miss_entry_idx_t    dc_idx;
   logic                  sq_ready, sq_sync, sq_ack;
   cache_line_index_t     sq_adr;
   l1_miss_entry_idx_t    sq_idx;
   cache_line_data_t      sq_data;
   cache_line_byte_mask_t sq_mask;
   logic                  l2_credit_return, drain, drained, l2_request_valid;
   l2req_packet_t         l2_request;

   always #5 clk = ~clk;

   l2_request_arbiter #(.NUM_CREDITS(NC)) dut (
      .clk                 (clk),
      .reset               (reset),
      .icache_dequeue_ready(ic_ready),
      .icache_dequeue_adr  (ic_adr),
      .icache_dequeue_idx  (ic_idx),
      .icache_dequeue_ack  (ic_ack),
      .dcache_dequeue_ready(dc_ready),
      .dcache_dequeue_adr  (dc_adr),
      .dcache_dequeue_idx  (dc_idx),
      .dcache_dequeue_sync (dc_sync),
      .dcache_dequeue_ack  (dc_ack),
      .sq_dequeue_ready    (sq_ready),
      .sq_dequeue_adr      (sq_adr),
      .sq_dequeue_idx      (sq_idx),
      .sq_dequeue_data     (sq_data),
      .sq_dequeue_mask     (sq_mask),
      .sq_dequeue_sync     (sq_sync),
      .sq_dequeue_ack      (sq_ack),
      .l2_credit_return    (l2_credit_return),
      .drain               (drain),
      .drained             (drained),
      .l2_request_valid    (l2_request_valid),
      .l2_request          (l2_request)
   );

   int tests = 0;
   int failed = 0;

   // Reference model state
   int            credits = NC;
   int            ptr = 0;
   logic          exp_valid = 1'b0;
   l2req_packet_t exp_pkt = '0;
   bit            known = 1'b0;
   int            last_win = -1;
   int            ack_count = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic src_ready(input int s);
      case (s)
         0:       return ic_ready;
         1:       return dc_ready;
         default: return sq_ready;
      endcase
   endfunction

   task automatic randomize_payload();
      ic_adr  = cache_line_index_t'($urandom);
      ic_idx  = l1_miss_entry_idx_t'($urandom);
      dc_adr  = cache_line_index_t'($urandom);
      dc_idx  = l1_miss_entry_idx_t'($urandom);
      dc_sync = 1'($urandom_range(0, 1));
      sq_adr  = cache_line_index_t'($urandom);
      sq_idx  = l1_miss_entry_idx_t'($urandom);
      sq_data = {$urandom, $urandom, $urandom, $urandom};
      sq_mask = cache_line_byte_mask_t'($urandom);
      sq_sync = 1'($urandom_range(0, 1));
   endtask

   // One clock cycle: inputs were driven just after the previous rising edge;
   // outputs are checked on the falling edge, then the model advances.
   task automatic run_cycle();
      int            win;
      int            s;
      logic [2:0]    exp_ack;
      l2req_packet_t p;
      @(negedge clk);
      win = -1;
      if (reset && credits > 0 && !drain) begin
         for (int k = 0; k < 3; k++) begin
            s = (ptr + k) % 3;
            if (win < 0 && src_ready(s)) win = s;
         end
      end
      exp_ack = (win >= 0) ? 3'(1 << win) : 3'b000;
      check("acks", {sq_ack, dc_ack, ic_ack}, exp_ack);
      if (known) begin
         check("l2_request_valid", l2_request_valid, exp_valid);
         check("drained", drained, (credits == NC) && !exp_valid);
         check("credit_count", dut.credit_count, credits);
         if (exp_valid) begin
            check("pkt_source", l2_request.source, exp_pkt.source);
            check("pkt_idx", l2_request.idx, exp_pkt.idx);
            check("pkt_adr", l2_request.adr, exp_pkt.adr);
            check("pkt_type", l2_request.req_type, exp_pkt.req_type);
            check("pkt_data", l2_request.data, exp_pkt.data);
            check("pkt_mask", l2_request.mask, exp_pkt.mask);
         end
      end
      p = '0;
      if (win == 0) begin
         p.source = SRC_ICACHE; p.idx = ic_idx; p.adr = ic_adr; p.req_type = LOAD;
      end else if (win == 1) begin
         p.source = SRC_DCACHE; p.idx = dc_idx; p.adr = dc_adr;
         p.req_type = dc_sync ? LOAD_SYNC : LOAD;
      end else if (win == 2) begin
         p.source = SRC_SQ; p.idx = sq_idx; p.adr = sq_adr;
         p.req_type = sq_sync ? STORE_SYNC : STORE;
         p.data = sq_data; p.mask = sq_mask;
      end
      last_win = win;
      if (win >= 0) ack_count++;
      if (!reset) begin
         credits = NC; ptr = 0; exp_valid = 1'b0; known = 1'b1;
      end else begin
         if (win >= 0 && !l2_credit_return) credits--;
         else if (win < 0 && l2_credit_return && credits < NC) credits++;
         if (win >= 0) begin
            ptr = (win + 1) % 3;
            exp_pkt = p;
         end
         exp_valid = (win >= 0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int order [4] = '{0, 1, 2, 0};
      int acks_before;
      reset = 1'b0; drain = 1'b0; l2_credit_return = 1'b0;
      ic_ready = 1'b1; dc_ready = 1'b1; sq_ready = 1'b1;
      randomize_payload();
      @(posedge clk);
      #1;
      run_cycle();
      run_cycle();
      reset = 1'b1;
      ic_ready = 1'b0; dc_ready = 1'b0; sq_ready = 1'b0;
      check("reset_valid", l2_request_valid, 1'b0);
      check("reset_credits", dut.credit_count, NC);
      check("drained_after_reset", drained, 1'b1);

      // All sources ready: strict rotation icache, dcache, sq, icache
      ic_ready = 1'b1; dc_ready = 1'b1; sq_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         randomize_payload();
         run_cycle();
         check("rr_order", last_win, order[i]);
      end
      ic_ready = 1'b0; dc_ready = 1'b0; sq_ready = 1'b0;
      l2_credit_return = 1'b1;
      for (int i = 0; i < 4; i++) run_cycle();
      l2_credit_return = 1'b0;

      // dcache ready forever, no returns: exactly NC acks
      ack_count = 0;
      dc_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         randomize_payload();
         run_cycle();
      end
      check("credit_exhaust_acks", ack_count, NC);
      check("credit_exhaust_count", dut.credit_count, 0);
      // Return and ready together at zero credits: no ack, grant next cycle
      l2_credit_return = 1'b1;
      run_cycle();
      check("zero_credit_no_ack", last_win, -1);
      check("zero_credit_return", dut.credit_count, 1);
      l2_credit_return = 1'b0;
      run_cycle();
      check("grant_after_return", last_win, 1);
      check("total_acks", ack_count, NC + 1);

      // Grant and return in the same cycle at two credits
      dc_ready = 1'b0;
      l2_credit_return = 1'b1;
      run_cycle();
      run_cycle();
      dc_ready = 1'b1;
      run_cycle();
      check("grant_and_return_win", last_win, 1);
      check("grant_and_return_count", dut.credit_count, 2);
      dc_ready = 1'b0;
      run_cycle();
      run_cycle();
      l2_credit_return = 1'b0;

      // Store sync packet contents
      sq_ready = 1'b1; sq_sync = 1'b1; sq_adr = cache_line_index_t'(32'h1234);
      sq_mask = '1; sq_idx = l1_miss_entry_idx_t'(5);
      run_cycle();
      sq_ready = 1'b0;
      check("sq_sync_valid", l2_request_valid, 1'b1);
      check("sq_sync_type", l2_request.req_type, STORE_SYNC);
      check("sq_sync_adr", l2_request.adr, 32'h1234);
      check("sq_sync_source", l2_request.source, 2);
      check("sq_sync_idx", l2_request.idx, 5);
      check("sq_sync_mask", l2_request.mask, 16'hffff);

      // Drain with three credits outstanding
      ic_ready = 1'b1;
      run_cycle();
      run_cycle();
      check("pre_drain_credits", dut.credit_count, 1);
      drain = 1'b1;
      ic_ready = 1'b1; dc_ready = 1'b1; sq_ready = 1'b1;
      acks_before = ack_count;
      for (int i = 0; i < 6; i++) begin
         l2_credit_return = (i % 2 == 1);
         run_cycle();
         if (i == 3) check("not_drained_yet", drained, 1'b0);
      end
      l2_credit_return = 1'b0;
      check("drain_no_acks", ack_count, acks_before);
      check("drained_after_returns", drained, 1'b1);
      drain = 1'b0;
      ic_ready = 1'b0; dc_ready = 1'b0; sq_ready = 1'b0;
      run_cycle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         randomize_payload();
         ic_ready = 1'($urandom_range(0, 1));
         dc_ready = 1'($urandom_range(0, 1));
         sq_ready = 1'($urandom_range(0, 1));
         drain = ($urandom_range(0, 9) == 0);
         l2_credit_return = (credits < NC) && ($urandom_range(0, 2) != 0);
         run_cycle();
      end
      drain = 1'b0;
      ic_ready = 1'b0; dc_ready = 1'b0; sq_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         l2_credit_return = (credits < NC);
         run_cycle();
      end
      l2_credit_return = 1'b0;

      // Reset while a registered request is in flight
      ic_ready = 1'b1;
      run_cycle();
      check("pre_reset_grant", last_win, 0);
      reset = 1'b0;
      run_cycle();
      reset = 1'b1;
      ic_ready = 1'b0;
      check("reset_mid_valid", l2_request_valid, 1'b0);
      check("reset_mid_credits", dut.credit_count, NC);
      check("reset_mid_drained", drained, 1'b1);
      run_cycle();
      run_cycle();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
